// File: rtl/dut_master_pkg.sv
// Shared types and dut register map for the dut bus master.
package dut_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POLL_A,
        ST_WR_A,
        ST_POLL_B,
        ST_WR_B,
        ST_POLL_Y,
        ST_RD_Y,
        ST_OUT
    } state_e;

    localparam int unsigned DUT_A_FULLN  = 0;
    localparam int unsigned DUT_B_FULLN  = 1;
    localparam int unsigned DUT_Y_EMPTYN = 2;
    localparam int unsigned DUT_Y_DATA   = 3;
    localparam int unsigned DUT_A_WR     = 4;
    localparam int unsigned DUT_B_WR     = 5;

endpackage

// File: rtl/dut_poll_timer.sv
// Per-poll-state failure counter; flags the failed poll that reaches POLL_TO.
module dut_poll_timer #(
    parameter int POLL_TO = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expired
);
    localparam int W = $clog2(POLL_TO + 1);
    localparam logic [W-1:0] LAST = W'(POLL_TO - 1);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + W'(1);
        end
    end

    assign expired = inc && (count_q == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dut_bus_master.sv
// Drives one (a,b) pair at a time through the OR/FIFO dut and returns y.
// Define DUT_MASTER_TIMEOUT_EN to bound polling and raise a sticky err on timeout.
module dut_bus_master #(
    parameter int ADDR_W  = 3,
    parameter int POLL_TO = 1023,
    parameter int CNT_W   = 16
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_a,
    input  logic              in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_y,
    output logic [ADDR_W-1:0] write_address,
    output logic              write_data,
    output logic              write_en,
    input  logic              write_rdy,
    output logic [ADDR_W-1:0] read_address,
    output logic              read_en,
    input  logic              read_data,
    input  logic              read_rdy,
    output logic [CNT_W-1:0]  txn_count,
    output logic              err
);
    import dut_master_pkg::*;

    state_e           state_q, state_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             y_q, y_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic             rd_beat, wr_beat;
    logic             poll_expired;

    assign rd_beat = read_en && read_rdy;
    assign wr_beat = write_en && write_rdy;

`ifdef DUT_MASTER_TIMEOUT_EN
    logic is_poll;
    logic poll_fail;
    logic err_q;

    assign is_poll   = (state_q == ST_POLL_A) || (state_q == ST_POLL_B) || (state_q == ST_POLL_Y);
    assign poll_fail = is_poll && rd_beat && !read_data;

    // Leaving a poll state always passes through a non-poll state, so this clears on every entry.
    dut_poll_timer #(.POLL_TO(POLL_TO)) u_poll_timer (
        .clk     (CLK),
        .rst_n   (RST_N),
        .clear   (!is_poll),
        .inc     (poll_fail),
        .expired (poll_expired)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | poll_expired;
        end
    end

    assign err = RST_N & err_q;
`else
    assign poll_expired = 1'b0;
    assign err          = 1'b0;

    if (POLL_TO < 1) begin : g_poll_to_unused
    end
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        y_d     = y_q;
        txn_d   = txn_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    state_d = ST_POLL_A;
                end
            end
            ST_POLL_A: if (rd_beat && read_data) state_d = ST_WR_A;
            ST_WR_A:   if (wr_beat) state_d = ST_POLL_B;
            ST_POLL_B: if (rd_beat && read_data) state_d = ST_WR_B;
            ST_WR_B:   if (wr_beat) state_d = ST_POLL_Y;
            ST_POLL_Y: if (rd_beat && read_data) state_d = ST_RD_Y;
            ST_RD_Y: begin
                if (rd_beat) begin
                    y_d     = read_data;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    txn_d   = txn_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (poll_expired) begin
            state_d = ST_IDLE;
        end
    end

    // Outputs decode registered state only and are forced low while reset is held.
    always_comb begin
        in_ready      = 1'b0;
        out_valid     = 1'b0;
        write_address = '0;
        write_data    = 1'b0;
        write_en      = 1'b0;
        read_address  = '0;
        read_en       = 1'b0;
        if (RST_N) begin
            case (state_q)
                ST_IDLE:   in_ready = 1'b1;
                ST_POLL_A: begin read_address = ADDR_W'(DUT_A_FULLN);  read_en = 1'b1; end
                ST_WR_A:   begin write_address = ADDR_W'(DUT_A_WR); write_data = a_q; write_en = 1'b1; end
                ST_POLL_B: begin read_address = ADDR_W'(DUT_B_FULLN);  read_en = 1'b1; end
                ST_WR_B:   begin write_address = ADDR_W'(DUT_B_WR); write_data = b_q; write_en = 1'b1; end
                ST_POLL_Y: begin read_address = ADDR_W'(DUT_Y_EMPTYN); read_en = 1'b1; end
                ST_RD_Y:   begin read_address = ADDR_W'(DUT_Y_DATA);   read_en = 1'b1; end
                ST_OUT:    out_valid = 1'b1;
                default:   in_ready = 1'b0;
            endcase
        end
    end

    assign out_y     = RST_N & y_q;
    assign txn_count = RST_N ? txn_q : '0;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            y_q     <= 1'b0;
            txn_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            y_q     <= y_d;
            txn_q   <= txn_d;
        end
    end

endmodule

// File: tb/tb_dut_bus_master.sv
// Directed bench for dut_bus_master against a small behavioural OR/FIFO dut model.
module tb_dut_bus_master;

    localparam int ADDR_W = 3;
    localparam int CNT_W  = 16;

    logic              CLK;
    logic              RST_N;
    logic              in_valid, in_ready, in_a, in_b;
    logic              out_valid, out_ready, out_y;
    logic [ADDR_W-1:0] write_address, read_address;
    logic              write_data, write_en, write_rdy;
    logic              read_en, read_data, read_rdy;
    logic [CNT_W-1:0]  txn_count;
    logic              err;

    int checks   = 0;
    int failures = 0;

    // dut model state and stub controls
    logic m_a_v, m_a_d, m_b_v, m_b_d, m_y_v, m_y_d;
    logic stub_a_block, stub_y_stuck;

    // bus beat monitors, read as deltas
    int wr4_cnt = 0, wr5_cnt = 0, poll0_cnt = 0, poll2_cnt = 0, strobe_cnt = 0;
    logic wr4_last = 1'b0, wr5_last = 1'b0;

    dut_bus_master #(.ADDR_W(ADDR_W), .POLL_TO(15), .CNT_W(CNT_W)) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_y         (out_y),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy),
        .txn_count     (txn_count),
        .err           (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always_comb begin
        read_data = 1'b0;
        case (read_address)
            3'd0: read_data = !m_a_v && !stub_a_block;
            3'd1: read_data = !m_b_v;
            3'd2: read_data = m_y_v && !stub_y_stuck;
            3'd3: read_data = m_y_d;
            default: read_data = 1'b0;
        endcase
    end

    always @(posedge CLK) begin
        if (!RST_N) begin
            m_a_v <= 1'b0; m_a_d <= 1'b0;
            m_b_v <= 1'b0; m_b_d <= 1'b0;
            m_y_v <= 1'b0; m_y_d <= 1'b0;
        end else begin
            if (write_en && write_rdy && write_address == 3'd4) begin
                m_a_v <= 1'b1; m_a_d <= write_data;
            end
            if (write_en && write_rdy && write_address == 3'd5) begin
                m_b_v <= 1'b1; m_b_d <= write_data;
            end
            if (m_a_v && m_b_v && !m_y_v) begin
                m_y_v <= 1'b1; m_y_d <= m_a_d | m_b_d;
                m_a_v <= 1'b0; m_b_v <= 1'b0;
            end
            if (read_en && read_rdy && read_address == 3'd3) m_y_v <= 1'b0;
        end
    end

    always @(posedge CLK) begin
        if (RST_N) begin
            if (write_en && write_rdy && write_address == 3'd4) begin wr4_cnt++; wr4_last = write_data; end
            if (write_en && write_rdy && write_address == 3'd5) begin wr5_cnt++; wr5_last = write_data; end
            if (read_en && read_rdy && read_address == 3'd0) poll0_cnt++;
            if (read_en && read_rdy && read_address == 3'd2) poll2_cnt++;
            if (write_en || read_en) strobe_cnt++;
        end
    end

    function automatic logic [31:0] allOutputs();
        return 32'({in_ready, out_valid, out_y, write_data, write_en, read_en, err,
                    write_address, read_address, txn_count});
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic a, input logic b);
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("accept_ready", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic collectResult(input string tag, input logic expected_y);
        int n = 0;
        while (!out_valid && n < 600) begin
            @(negedge CLK);
            n++;
        end
        checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_y"}, 32'(out_y), 32'(expected_y));
        out_ready = 1'b1;
        @(negedge CLK);
        out_ready = 1'b0;
    endtask

    initial begin
        int w4, w5, p0, p2, st, bad, n;
        logic y_seen, saw_out, saw_wrb;

        RST_N = 1'b0; in_valid = 1'b0; in_a = 1'b0; in_b = 1'b0; out_ready = 1'b0;
        write_rdy = 1'b1; read_rdy = 1'b1; stub_a_block = 1'b0; stub_y_stuck = 1'b0;

        // Reset, then one transaction a=1 b=0
        repeat (3) @(negedge CLK);
        checkOutput("reset_outputs_zero", allOutputs(), 32'd0);
        RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("post_reset_txn", 32'(txn_count), 32'd0);
        checkOutput("post_reset_err", 32'(err), 32'd0);
        checkOutput("post_reset_out_y", 32'(out_y), 32'd0);
        w4 = wr4_cnt; w5 = wr5_cnt;
        applyStimulus(1'b1, 1'b0);
        collectResult("t1", 1'b1);
        checkOutput("t1_wr4_count", 32'(wr4_cnt - w4), 32'd1);
        checkOutput("t1_wr4_data", 32'(wr4_last), 32'd1);
        checkOutput("t1_wr5_count", 32'(wr5_cnt - w5), 32'd1);
        checkOutput("t1_wr5_data", 32'(wr5_last), 32'd0);
        checkOutput("t1_txn", 32'(txn_count), 32'd1);

        // OR truth table, last two back-to-back
        applyStimulus(1'b0, 1'b0);
        collectResult("t2_00", 1'b0);
        applyStimulus(1'b0, 1'b1);
        collectResult("t2_01", 1'b1);
        checkOutput("t2_ready_after_out", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 1'b1);
        collectResult("t2_11", 1'b1);
        checkOutput("t2_txn", 32'(txn_count), 32'd4);

        // Backpressure in OUT
        applyStimulus(1'b1, 1'b1);
        n = 0;
        while (!out_valid && n < 600) begin @(negedge CLK); n++; end
        checkOutput("t3_valid_seen", 32'(out_valid), 32'd1);
        y_seen = out_y; st = strobe_cnt; bad = 0;
        repeat (20) begin
            @(negedge CLK);
            if (!out_valid || out_y !== y_seen || in_ready) bad++;
        end
        checkOutput("t3_hold_stable", 32'(bad), 32'd0);
        checkOutput("t3_y", 32'(out_y), 32'd1);
        checkOutput("t3_no_strobes", 32'(strobe_cnt - st), 32'd0);
        collectResult("t3", 1'b1);
        checkOutput("t3_txn", 32'(txn_count), 32'd5);

        // a FIFO full for 10 cycles, then write stall
        stub_a_block = 1'b1;
        p0 = poll0_cnt; w4 = wr4_cnt;
        applyStimulus(1'b1, 1'b0);
        repeat (10) @(negedge CLK);
        checkOutput("t4_poll_beats", 32'(poll0_cnt - p0), 32'd10);
        checkOutput("t4_no_write", 32'(wr4_cnt - w4), 32'd0);
        stub_a_block = 1'b0;
        write_rdy    = 1'b0;
        @(negedge CLK);
        bad = 0;
        repeat (5) begin
            @(negedge CLK);
            if (!write_en || write_address !== 3'd4 || write_data !== 1'b1) bad++;
        end
        checkOutput("t4_write_held", 32'(bad), 32'd0);
        checkOutput("t4_no_write_stalled", 32'(wr4_cnt - w4), 32'd0);
        write_rdy = 1'b1;
        collectResult("t4", 1'b1);
        checkOutput("t4_one_write", 32'(wr4_cnt - w4), 32'd1);
        checkOutput("t4_txn", 32'(txn_count), 32'd6);

        // y never ready
        stub_y_stuck = 1'b1;
        p2 = poll2_cnt;
        applyStimulus(1'b0, 1'b1);
`ifdef DUT_MASTER_TIMEOUT_EN
        saw_out = 1'b0; n = 0;
        while (!in_ready && n < 200) begin
            @(negedge CLK);
            if (out_valid) saw_out = 1'b1;
            n++;
        end
        checkOutput("t5_err", 32'(err), 32'd1);
        checkOutput("t5_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t5_poll_count", 32'(poll2_cnt - p2), 32'd15);
        checkOutput("t5_txn_unchanged", 32'(txn_count), 32'd6);
        checkOutput("t5_no_out_valid", 32'(saw_out), 32'd0);
`else
        repeat (60) @(negedge CLK);
        checkOutput("t5_still_polling", 32'({read_en, read_address}), 32'({1'b1, 3'd2}));
        checkOutput("t5_err_zero", 32'(err), 32'd0);
        checkOutput("t5_in_ready_low", 32'(in_ready), 32'd0);
        checkOutput("t5_txn_unchanged", 32'(txn_count), 32'd6);
`endif
        stub_y_stuck = 1'b0;
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        checkOutput("t5_reset_err", 32'(err), 32'd0);
        applyStimulus(1'b1, 1'b1);
        collectResult("t6_pre", 1'b1);
        checkOutput("t6_pre_txn", 32'(txn_count), 32'd1);

        // Reset while in WR_B
        applyStimulus(1'b1, 1'b0);
        saw_wrb = 1'b0; n = 0;
        while (!saw_wrb && n < 100) begin
            if (write_en && write_address == 3'd5) saw_wrb = 1'b1;
            else begin @(negedge CLK); n++; end
        end
        checkOutput("t6_reached_wr_b", 32'(saw_wrb), 32'd1);
        RST_N = 1'b0;
        #1;
        checkOutput("t6_reset_outputs_zero", allOutputs(), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t6_txn", 32'(txn_count), 32'd0);
        checkOutput("t6_err", 32'(err), 32'd0);
        checkOutput("t6_out_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
